// File: rtl/circulant_word_packer.sv
// circulant_word_packer
// Packs IN_WIDTH-bit bytes into OUT_WIDTH-bit circulant words for the
// downstream sparse C multiplier. Bytes are placed little-endian: the first
// accepted byte of a word lands in the least significant lane.
//
// Datapath: per-lane accumulator, a byte counter, and a single output
// register (data + valid) with a valid/ready handshake on both sides.
// Only the word-completing byte can be back-pressured, so bytes 0..N-2 of
// the next word keep flowing while a finished word waits downstream.
//
// Optional feature: define CIRCULANT_WORD_PACKER_LAST_EN to add a word
// counter and the o_output_last frame marker. Without the macro the port
// and counter do not exist.

module circulant_word_packer #(
  parameter int IN_WIDTH        = 8,
  parameter int OUT_WIDTH       = 96,
  parameter int WORDS_PER_FRAME = 144
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IN_WIDTH-1:0]  i_input_data,
  input  logic                 i_input_valid,
  output logic                 o_input_ready,
  output logic [OUT_WIDTH-1:0] o_output_data,
  output logic                 o_output_valid,
  input  logic                 i_output_ready
`ifdef CIRCULANT_WORD_PACKER_LAST_EN
  ,
  output logic                 o_output_last
`endif
);

  // Bytes per packed word and the width of the byte counter.
  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(N - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [CW-1:0]        byte_cnt_reg;
  logic [CW-1:0]        byte_cnt_next;
  logic [IN_WIDTH-1:0]  acc_lane_reg [N];
  logic [OUT_WIDTH-1:0] data_reg;
  logic                 valid_reg;
  logic                 valid_next;

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------
  logic                 at_last_byte;  // next accepted byte completes a word
  logic                 out_can_load;  // output register is empty or draining
  logic                 accept;        // byte handshake this cycle
  logic                 load;          // completed word enters output register
  logic                 pop;           // word handshake this cycle
  logic [OUT_WIDTH-1:0] word_full;     // accumulator with the incoming byte merged

  assign at_last_byte  = (byte_cnt_reg == LAST_BYTE);
  assign out_can_load  = !valid_reg || i_output_ready;

  // Only the completing byte waits on the output register; reset holds
  // ready low so nothing is accepted while the block is being cleared.
  assign o_input_ready = !i_reset && (!at_last_byte || out_can_load);

  assign accept = i_input_valid && o_input_ready;
  assign load   = accept && at_last_byte;
  assign pop    = valid_reg && i_output_ready;

  // ------------------------------------------------------------------
  // Byte counter
  // ------------------------------------------------------------------

  // Next byte position: advance on acceptance, wrap after the last lane.
  always_comb begin
    byte_cnt_next = byte_cnt_reg;
    if (accept) begin
      if (at_last_byte) begin
        byte_cnt_next = '0;
      end else begin
        byte_cnt_next = byte_cnt_reg + CW'(1);
      end
    end
  end

  // Byte counter register; reset discards any partial word position.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt_reg <= '0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Accumulator lanes
  // ------------------------------------------------------------------
  // Each lane owns one byte slot of the word. The merged view word_full
  // substitutes the incoming byte into its lane so the completing byte can
  // be loaded into the output register in the same cycle it is accepted,
  // giving one-byte-per-cycle throughput with no bubble at word boundaries.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic lane_hit;

      assign lane_hit = accept && (byte_cnt_reg == CW'(gi));

      assign word_full[gi*IN_WIDTH +: IN_WIDTH] =
        lane_hit ? i_input_data : acc_lane_reg[gi];

      // Capture the accepted byte into this lane; idle cycles leave it alone.
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          acc_lane_reg[gi] <= '0;
        end else if (lane_hit) begin
          acc_lane_reg[gi] <= i_input_data;
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Output register
  // ------------------------------------------------------------------

  // Valid rises on a load, falls on a pop without a load, otherwise holds.
  always_comb begin
    valid_next = valid_reg;
    if (load) begin
      valid_next = 1'b1;
    end else if (pop) begin
      valid_next = 1'b0;
    end
  end

  // Output word and valid; data only changes on a load so it stays stable
  // while the downstream stalls.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (load) begin
        data_reg <= word_full;
      end
    end
  end

  // Data is presented unconditionally; downstream qualifies with valid.
  assign o_output_data  = data_reg;
  assign o_output_valid = valid_reg;

`ifdef CIRCULANT_WORD_PACKER_LAST_EN
  // ------------------------------------------------------------------
  // Frame tracking
  // ------------------------------------------------------------------
  localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_FRAME - 1);

  logic [WCW-1:0] word_cnt_reg;
  logic [WCW-1:0] word_cnt_next;
  logic           last_reg;
  logic           last_next;

  // Word index within the frame advances on every output load and wraps.
  // The last flag travels with the word it describes.
  always_comb begin
    word_cnt_next = word_cnt_reg;
    last_next     = last_reg;
    if (load) begin
      last_next = (word_cnt_reg == LAST_WORD);
      if (word_cnt_reg == LAST_WORD) begin
        word_cnt_next = '0;
      end else begin
        word_cnt_next = word_cnt_reg + WCW'(1);
      end
    end else if (pop) begin
      last_next = 1'b0;
    end
  end

  // Frame counter and last flag; reset restarts the frame at word 0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_cnt_reg <= '0;
      last_reg     <= 1'b0;
    end else begin
      word_cnt_reg <= word_cnt_next;
      last_reg     <= last_next;
    end
  end

  assign o_output_last = last_reg;
`endif

endmodule

// File: doc/circulant_word_packer.md
CIRCULANT_WORD_PACKER -- requirements
Module: circulant_word_packer

Interface
REQ-001 The module SHALL have these parameters, one per line as name, default, meaning:
  IN_WIDTH  8  input byte width; OUT_WIDTH SHALL be an integer multiple of it.
  OUT_WIDTH  96  packed circulant word width, matching the downstream sparse C multiplier.
  WORDS_PER_FRAME  144  packed words per code frame.
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
  i_clock  input  1  single clock; all logic on its rising edge.
  i_reset  input  1  asynchronous, active-high reset.
  i_input_data  input  IN_WIDTH  input byte.
  i_input_valid  input  1  byte valid.
  o_input_ready  output  1  byte accepted when valid and ready are both high.
  o_output_data  output  OUT_WIDTH  packed word to the downstream C multiplier.
  o_output_valid  output  1  word valid.
  i_output_ready  input  1  word consumed when valid and ready are both high.
  o_output_last  output  1  last word of a frame; present only under REQ-017.
REQ-003 One clock; reset is asynchronous and active-high, via i_clock and i_reset.

Function
REQ-004 The block SHALL pack N = OUT_WIDTH/IN_WIDTH accepted bytes into one word, little-endian: byte k of a word lands in bits [k*IN_WIDTH +: IN_WIDTH] (first byte in LSBs).
REQ-005 Datapath SHALL be an accumulator register, a byte counter byte_cnt (0..N-1) and a single output register holding o_output_data and o_output_valid.
REQ-006 Byte acceptance SHALL increment byte_cnt; the byte with byte_cnt = N-1 completes the word, and byte_cnt SHALL wrap to 0.
REQ-007 o_input_ready SHALL be high when byte_cnt < N-1, or when byte_cnt = N-1 and the output register can load (o_output_valid low, or i_output_ready high); it is combinational from registered state and i_output_ready.
REQ-008 On acceptance of the completing byte, the output register SHALL load the full word and o_output_valid SHALL rise on the next cycle (latency 1 cycle from last byte).
REQ-009 Sustained throughput SHALL be one byte per cycle with i_output_ready held high; no bubble at word boundaries.
REQ-010 A word pop with no simultaneous load SHALL clear o_output_valid; simultaneous pop and load SHALL keep it high with new data.
REQ-011 While o_output_valid is high and i_output_ready is low, o_output_data SHALL hold stable; bytes 0..N-2 of the next word SHALL still be accepted.
REQ-012 Input valid low SHALL not advance byte_cnt or disturb the accumulator.
REQ-013 o_output_data SHALL be driven from the register regardless of valid; downstream qualifies with valid.

Reset
REQ-014 i_reset high SHALL asynchronously clear byte_cnt, accumulator, o_output_data, o_output_valid, the frame counter and o_output_last to 0.
REQ-015 Reset mid-word or mid-frame SHALL discard the partial word and frame; the first byte after deassertion is byte 0 of word 0.
REQ-016 o_input_ready SHALL be low while i_reset is high.

Configuration
REQ-017 Macro CIRCULANT_WORD_PACKER_LAST_EN defined: a word counter (0..WORDS_PER_FRAME-1) SHALL advance on each output-register load and wrap; o_output_last SHALL be registered alongside the word and SHALL be high exactly with word WORDS_PER_FRAME-1.
REQ-018 Macro undefined: the o_output_last port and word counter SHALL be absent; all other behaviour is identical.

Verification
REQ-019 Bytes 0x01..0x0C back-to-back, ready high -> one word 0x0C0B0A090807060504030201, valid one cycle after byte 12.
REQ-020 1728 bytes continuous, ready high -> 144 words, o_input_ready never low, with LAST_EN o_output_last only on word 144.
REQ-021 Ready low after word 1 completes, 11 more bytes sent -> all accepted, 12th stalls (o_input_ready low), word 1 stable; ready high -> word 1 pops and word 2 loads in the same cycle.
REQ-022 Random valid gaps and random downstream ready -> output words equal a reference packing model, none lost or duplicated.
REQ-023 Reset asserted after byte 5 of a word -> outputs 0 immediately; next 12 bytes form word 0 with no residue from the aborted bytes.
